// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding controller for the 5-stage core. It keeps a shadow
//   copy of the EXE/MEM/WB destination info and, from it, produces per-source
//   forwarding selects, load-use stalls and branch/jump squashes for decode.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   id_valid       decode stage holds a real instruction
//   id_src_addr    source register addresses, src i at [i*AW +: AW]
//   id_src_used    source i is actually read
//   id_dst_addr    destination register of the decoded instruction
//   id_wreg        decoded instruction writes the register file
//   id_is_load     decoded instruction is a load
//   id_is_jump     unconditional jump, resolved in ID
//   ex_br_taken    branch currently in EXE is taken
//   stall          freeze PC and IF/ID, insert bubble into EXE
//   issue          ID instruction advances into EXE this cycle
//   flush_ifid     squash the instruction being written into IF/ID
//   fwd_sel        per source: 0 regfile, 1 EXE, 2 MEM, 3 WB
//   stall_cycles   saturating count of stall cycles
//   flush_cycles   saturating count of squash cycles
module hazard_fwd_unit #(
  parameter int AW        = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_EN    = 1,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NUM_SRC*AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic [AW-1:0]           id_dst_addr,
  input  logic                    id_wreg,
  input  logic                    id_is_load,
  input  logic                    id_is_jump,
  input  logic                    ex_br_taken,
  output logic                    stall,
  output logic                    issue,
  output logic                    flush_ifid,
  output logic [2*NUM_SRC-1:0]    fwd_sel,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        flush_cycles
);

  localparam int FCW = $clog2(FLUSH_CYC + 1);

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic [AW-1:0] dst;
    logic          is_load;
  } stage_t;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  stage_t ex_q, mem_q;
  // The WB copy never needs is_load: nothing past WB is a load-use source.
  logic          wb_valid_q, wb_wreg_q;
  logic [AW-1:0] wb_dst_q;

  state_t         state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic [NUM_SRC-1:0] m_ex, m_mem, m_wb;
  logic               hazard;

  function automatic logic src_match(input logic v, input logic w,
                                     input logic [AW-1:0] dst,
                                     input logic [AW-1:0] src,
                                     input logic used);
    return v && w && used && (src == dst) && (dst != '0);
  endfunction

  // Per-source match against each shadow stage
  always_comb begin
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      m_ex[i]  = src_match(ex_q.valid, ex_q.wreg, ex_q.dst,
                           id_src_addr[i*AW +: AW], id_src_used[i]);
      m_mem[i] = src_match(mem_q.valid, mem_q.wreg, mem_q.dst,
                           id_src_addr[i*AW +: AW], id_src_used[i]);
      m_wb[i]  = src_match(wb_valid_q, wb_wreg_q, wb_dst_q,
                           id_src_addr[i*AW +: AW], id_src_used[i]);
    end
  end

  // Hazard detection and forwarding select
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = '0;
    if (FWD_EN != 0) begin
      hazard = ((|m_ex) && ex_q.is_load) ||
               ((LOAD_LAT == 2) && (|m_mem) && mem_q.is_load);
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (m_ex[i])       fwd_sel[2*i +: 2] = 2'd1;
        else if (m_mem[i]) fwd_sel[2*i +: 2] = 2'd2;
        else if (m_wb[i])  fwd_sel[2*i +: 2] = 2'd3;
        else               fwd_sel[2*i +: 2] = 2'd0;
      end
    end else begin
      // WB writes in the first half-cycle, so only EXE/MEM writers block.
      hazard = (|m_ex) || (|m_mem);
    end
  end

  // Control FSM: branch squash > hazard stall > jump squash
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    stall      = 1'b0;
    issue      = 1'b0;
    flush_ifid = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ex_br_taken) begin
          flush_ifid = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FCW'(FLUSH_CYC - 1);
          end
        end else if (hazard && id_valid) begin
          stall = 1'b1;
        end else begin
          issue      = id_valid;
          flush_ifid = id_valid && id_is_jump;
        end
      end
      S_FLUSH: begin
        // fcnt holds the FLUSH cycles still to come, including this one, so
        // the branch cycle plus the FLUSH cycles total FLUSH_CYC squashes.
        flush_ifid = 1'b1;
        if (fcnt_q <= FCW'(1)) begin
          state_d = S_RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Shadow pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_wreg_q  <= 1'b0;
      wb_dst_q   <= '0;
    end else begin
      wb_valid_q <= mem_q.valid;
      wb_wreg_q  <= mem_q.wreg;
      wb_dst_q   <= mem_q.dst;
      mem_q      <= ex_q;
      if (issue) begin
        ex_q.valid   <= 1'b1;
        ex_q.wreg    <= id_wreg;
        ex_q.dst     <= id_dst_addr;
        ex_q.is_load <= id_is_load;
      end else begin
        ex_q <= '0;
      end
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_ifid && (flush_cycles != '1))
        flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end

endmodule
